// File: rtl/p_bit_gibbs_engine_pkg.sv
// Shared types and helpers for the sequential p-bit Gibbs engine: FSM states,
// default LFSR seed/taps, clog2 and signed saturation.
package p_bit_gibbs_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_MUL,
        ST_UPD
    } state_e;

    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Clamp v into the signed range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/p_bit_gibbs_engine_lfsr.sv
// Galois right-shift LFSR that advances only when enabled; the state is the
// random source read as a signed number by p-bit comparators.
module pbit_lfsr_galois
    import p_bit_gibbs_engine_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] SEED = LFSR_SEED_DEF,
    parameter logic [W-1:0] TAPS = LFSR_TAPS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] state
);

    logic [W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en) state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/p_bit_gibbs_engine.sv
// Time-multiplexed Gibbs sweep over N p-bits with one shared MAC/beta/compare.
// Optional ANNEAL_EN adds beta_step: working beta grows at each sweep boundary.
module p_bit_gibbs_engine
    import p_bit_gibbs_engine_pkg::*;
#(
    parameter int                N         = 8,
    parameter int                W_J       = 8,
    parameter int                W_H       = 8,
    parameter int                W_BETA    = 8,
    parameter int                BETA_FRAC = 4,
    parameter int                W_RND     = 16,
    parameter logic [W_RND-1:0]  LFSR_SEED = LFSR_SEED_DEF,
    parameter logic [W_RND-1:0]  LFSR_TAPS = LFSR_TAPS_DEF,
    parameter int                W_SWP     = 8
) (
    input  logic                        clk_mac,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [W_SWP-1:0]            n_sweeps,
    input  logic [W_BETA-1:0]           i_beta,
`ifdef ANNEAL_EN
    input  logic [W_BETA-1:0]           beta_step,
`endif
    input  logic [N*W_H-1:0]            h_in,
    input  logic                        spin_load,
    input  logic [N-1:0]                spin_init,
    output logic                        j_rd_en,
    output logic [clog2(N*N)-1:0]       j_addr,
    input  logic [W_J-1:0]              j_data,
    output logic                        busy,
    output logic                        done,
    output logic [N-1:0]                m_out
);

    localparam int CW    = clog2(N);
    localparam int AW    = clog2(N * N);
    localparam int HJ    = (W_J > W_H) ? W_J : W_H;
    localparam int ACC_W = HJ + CW + 2;
    localparam logic [CW:0]   CNT_LAST = (CW + 1)'(N);
    localparam logic [CW-1:0] I_LAST   = CW'(N - 1);

    state_e                    state_q, state_d;
    logic [CW:0]               cnt_q, cnt_d;
    logic [CW-1:0]             i_q, i_d;
    logic [W_SWP-1:0]          sweep_q, sweep_d, nsw_q, nsw_d;
    logic [W_BETA-1:0]         beta_q, beta_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [W_RND-1:0]   act_q, act_d;
    logic [N-1:0]              m_q, m_d;
    logic                      done_q, done_d;

    logic                      lfsr_en;
    logic [W_RND-1:0]          lfsr_state;
    logic [CW-1:0]             j_prev;
    logic signed [ACC_W-1:0]   j_ext, h_ext;
    logic signed [63:0]        prod, shifted, satv;
    logic [W_BETA:0]           beta_sum;

    pbit_lfsr_galois #(.W(W_RND), .SEED(LFSR_SEED), .TAPS(LFSR_TAPS)) u_lfsr (
        .clk   (clk_mac),
        .rst_n (reset_n),
        .en    (lfsr_en),
        .state (lfsr_state)
    );

    // j_data arriving in ACC cycle c belongs to column c-1 (one-cycle read latency).
    assign j_prev   = CW'(cnt_q - 1'b1);
    assign j_ext    = ACC_W'($signed(j_data));
    assign h_ext    = ACC_W'($signed(h_in[int'(i_q)*W_H +: W_H]));
    assign prod     = 64'(acc_q) * $signed({{(64-W_BETA){1'b0}}, beta_q});
    assign shifted  = prod >>> BETA_FRAC;
    assign satv     = sat_s(shifted, W_RND);
`ifdef ANNEAL_EN
    assign beta_sum = {1'b0, beta_q} + {1'b0, beta_step};
`else
    assign beta_sum = {1'b0, beta_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        sweep_d = sweep_q;
        nsw_d   = nsw_q;
        beta_d  = beta_q;
        acc_d   = acc_q;
        act_d   = act_q;
        m_d     = m_q;
        done_d  = 1'b0;
        lfsr_en = 1'b0;
        j_rd_en = 1'b0;
        j_addr  = '0;
        case (state_q)
            ST_IDLE: begin
                if (spin_load) m_d = spin_init;
                if (start) begin
                    nsw_d   = n_sweeps;
                    beta_d  = i_beta;
                    i_d     = '0;
                    sweep_d = '0;
                    cnt_d   = '0;
                    if (n_sweeps == '0) done_d = 1'b1;
                    else                state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (cnt_q < CNT_LAST) begin
                    j_rd_en = 1'b1;
                    j_addr  = AW'(int'(i_q) * N + int'(cnt_q));
                end
                if (cnt_q == '0)
                    acc_d = h_ext;
                else if (j_prev != i_q)
                    acc_d = m_q[j_prev] ? acc_q + j_ext : acc_q - j_ext;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MUL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MUL: begin
                act_d   = satv[W_RND-1:0];
                state_d = ST_UPD;
            end
            ST_UPD: begin
                m_d[i_q] = (act_q > $signed(lfsr_state));
                lfsr_en  = 1'b1;
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_d == nsw_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACC;
                        beta_d  = beta_sum[W_BETA] ? '1 : beta_sum[W_BETA-1:0];
                    end
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_mac or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            i_q     <= '0;
            sweep_q <= '0;
            nsw_q   <= '0;
            beta_q  <= '0;
            acc_q   <= '0;
            act_q   <= '0;
            m_q     <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            sweep_q <= sweep_d;
            nsw_q   <= nsw_d;
            beta_q  <= beta_d;
            acc_q   <= acc_d;
            act_q   <= act_d;
            m_q     <= m_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign m_out = m_q;

endmodule

// File: tb/tb_p_bit_gibbs_engine.sv
// Directed bench for p_bit_gibbs_engine at N=4: vector table plus handshake,
// reset-abort and (with ANNEAL_EN) beta ramp sequences.
module tb_p_bit_gibbs_engine;

    localparam int N = 4;

    logic            clk_mac = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      n_sweeps = '0;
    logic [7:0]      i_beta = '0;
    logic [N*8-1:0]  h_in = '0;
    logic            spin_load = 1'b0;
    logic [N-1:0]    spin_init = '0;
    logic            j_rd_en;
    logic [3:0]      j_addr;
    logic [7:0]      j_data;
    logic            busy;
    logic            done;
    logic [N-1:0]    m_out;
`ifdef ANNEAL_EN
    logic [7:0]      beta_step = '0;
`endif

    always #5 clk_mac = ~clk_mac;

    p_bit_gibbs_engine #(.N(N)) dut (
        .clk_mac   (clk_mac),
        .reset_n   (reset_n),
        .start     (start),
        .n_sweeps  (n_sweeps),
        .i_beta    (i_beta),
`ifdef ANNEAL_EN
        .beta_step (beta_step),
`endif
        .h_in      (h_in),
        .spin_load (spin_load),
        .spin_init (spin_init),
        .j_rd_en   (j_rd_en),
        .j_addr    (j_addr),
        .j_data    (j_data),
        .busy      (busy),
        .done      (done),
        .m_out     (m_out)
    );

    logic [7:0] jmem [16];
    always @(posedge clk_mac) if (j_rd_en) j_data <= jmem[j_addr];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int addr_q[$];

    always @(negedge clk_mac) begin
        if (j_rd_en) addr_q.push_back(int'(j_addr));
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference sweep model: sequential Gibbs update using its own LFSR copy.
    logic [15:0] lfsr_m = 16'hACE1;
    int          beta_step_v = 0;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_run(input int hv, input int beta, input int nsw,
                             input logic [N-1:0] init, output logic [N-1:0] m);
        int acc, act, rnd, b, jv;
        m = init;
        b = beta;
        for (int s = 0; s < nsw; s++) begin
            for (int i = 0; i < N; i++) begin
                acc = hv;
                for (int j = 0; j < N; j++) begin
                    if (j != i) begin
                        jv = int'($signed(jmem[i*N+j]));
                        acc += m[j] ? jv : -jv;
                    end
                end
                act = (acc * b) >>> 4;
                if (act > 32767)  act = 32767;
                if (act < -32768) act = -32768;
                rnd = int'($signed(lfsr_m));
                m[i] = (act > rnd);
                lfsr_m = lstep(lfsr_m);
            end
            if (s < nsw - 1) b = (b + beta_step_v > 255) ? 255 : b + beta_step_v;
        end
    endtask

    // jmode 0: uniform off-diagonal; 1: nearest-neighbour chain. Diagonal is
    // deliberately nonzero so any leakage of J[i][i] into the sum shows up.
    task automatic set_j(input int jmode, input int jv);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (i == j)                                      jmem[i*N+j] = 8'd77;
                else if (jmode == 0 || i - j == 1 || j - i == 1) jmem[i*N+j] = 8'(jv);
                else                                             jmem[i*N+j] = 8'd0;
            end
    endtask

    task automatic do_run(input int nsw, input int beta, input int hv, input logic [N-1:0] init,
                          input bit load, input int disturb, output int lat);
        h_in      = {N{8'(hv)}};
        i_beta    = 8'(beta);
        n_sweeps  = 8'(nsw);
        spin_init = init;
        addr_q.delete();
        @(negedge clk_mac);
        spin_load = load;
        start     = 1'b1;
        @(negedge clk_mac);
        spin_load = 1'b0;
        start     = 1'b0;
        spin_init = ~init;
        i_beta    = 8'd0;
        lat = 0;
        while (!done && lat < 2000) begin
            if (lat == disturb) begin
                start     = 1'b1;
                spin_load = 1'b1;
            end
            @(negedge clk_mac);
            start     = 1'b0;
            spin_load = 1'b0;
            lat++;
        end
    endtask

    typedef struct {
        int         jmode;
        int         jv;
        int         hv;
        int         beta;
        int         nsw;
        logic [3:0] init;
        logic [3:0] exp;
        bit         hand;
    } vec_t;

    vec_t tv[6];

    initial begin
        logic [N-1:0] mexp, mb;
        int lat, d0, bad;

        tv[0] = '{0,    0,    0,  16, 1, 4'b0000, 4'b0011, 1'b1};
        tv[1] = '{0,    0,  127, 255, 1, 4'b0000, 4'b1100, 1'b1};
        tv[2] = '{0,    0, -128, 255, 1, 4'b0000, 4'b1001, 1'b1};
        tv[3] = '{0,  100,    0, 255, 3, 4'b1110, 4'b0000, 1'b0};
        tv[4] = '{1, -100,    0, 255, 2, 4'b0000, 4'b0000, 1'b0};
        tv[5] = '{0,  -50,   20,  40, 2, 4'b1010, 4'b0000, 1'b0};

        set_j(0, 0);
        repeat (2) @(negedge clk_mac);
        chk("rst_m_out", 64'(m_out), 64'hF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_j_rd_en", 64'(j_rd_en), 64'd0);
        chk("rst_j_addr", 64'(j_addr), 64'd0);
        reset_n = 1'b1;
        @(negedge clk_mac);

        for (int v = 0; v < 6; v++) begin
            set_j(tv[v].jmode, tv[v].jv);
            model_run(tv[v].hv, tv[v].beta, tv[v].nsw, tv[v].init, mexp);
            if (tv[v].hand) mexp = tv[v].exp;
            do_run(tv[v].nsw, tv[v].beta, tv[v].hv, tv[v].init, 1'b1, -1, lat);
            chk($sformatf("vec%0d_m_out", v), 64'(m_out), 64'(mexp));
            chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(tv[v].nsw * N * (N + 3)));
            chk($sformatf("vec%0d_busy_end", v), 64'(busy), 64'd0);
            bad = -1;
            foreach (addr_q[k]) if (bad < 0 && addr_q[k] != k % (N * N)) bad = k;
            chk($sformatf("vec%0d_addr_count", v), 64'(addr_q.size()), 64'(tv[v].nsw * N * N));
            chk($sformatf("vec%0d_addr_seq_bad_idx", v), 64'(bad), 64'(-1));
            @(negedge clk_mac);
            chk($sformatf("vec%0d_done_one_cycle", v), 64'(done), 64'd0);
        end

        // start and spin_load while busy must be ignored
        set_j(0, 100);
        spin_init = 4'b1111;
        spin_load = 1'b1;
        @(negedge clk_mac);
        spin_load = 1'b0;
        chk("idle_spin_load", 64'(m_out), 64'hF);
        model_run(0, 255, 1, 4'b1111, mexp);
        d0 = done_cnt;
        do_run(1, 255, 0, 4'b1111, 1'b0, 10, lat);
        chk("busy_ign_m_out", 64'(m_out), 64'(mexp));
        chk("busy_ign_latency", 64'(lat), 64'(N * (N + 3)));
        repeat (40) @(negedge clk_mac);
        chk("busy_ign_no_restart", 64'(busy), 64'd0);
        chk("busy_ign_done_count", 64'(done_cnt - d0), 64'd1);

        // zero sweeps: done next cycle, spins untouched, never busy
        mb = m_out;
        do_run(0, 255, 0, ~mb, 1'b0, -1, lat);
        chk("nsw0_latency", 64'(lat), 64'd0);
        chk("nsw0_m_out", 64'(m_out), 64'(mb));
        chk("nsw0_busy", 64'(busy), 64'd0);
        @(negedge clk_mac);
        chk("nsw0_done_pulse", 64'(done), 64'd0);

        // reset during ACC of sweep 2, then replay of the first vector from seed
        set_j(0, 0);
        h_in = '0;
        i_beta = 8'd16;
        n_sweeps = 8'd3;
        @(negedge clk_mac);
        start = 1'b1;
        @(negedge clk_mac);
        start = 1'b0;
        repeat (30) @(negedge clk_mac);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_m_out", 64'(m_out), 64'hF);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_j_rd_en", 64'(j_rd_en), 64'd0);
        @(negedge clk_mac);
        reset_n = 1'b1;
        lfsr_m = 16'hACE1;
        @(negedge clk_mac);
        do_run(1, 16, 0, 4'b0000, 1'b1, -1, lat);
        chk("replay_m_out", 64'(m_out), 64'h3);
        chk("replay_latency", 64'(lat), 64'(N * (N + 3)));

`ifdef ANNEAL_EN
        beta_step = 8'd64;
        beta_step_v = 64;
        model_run(0, 0, 4, 4'b0000, mexp);
        do_run(4, 0, 0, 4'b0000, 1'b1, -1, lat);
        chk("anneal_beta_ramp", 64'(dut.beta_q), 64'd192);
        chk("anneal_m_out", 64'(m_out), 64'(mexp));
        model_run(0, 250, 2, 4'b0000, mexp);
        do_run(2, 250, 0, 4'b0000, 1'b1, -1, lat);
        chk("anneal_beta_sat", 64'(dut.beta_q), 64'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
